ahfp_add: RTL and testbench

AHFP_ADD -- requirements
Module: ahfp_add

---
 rtl/ahfp_add_if.sv | 14 +
 rtl/ahfp_add.sv | 155 +++++++++++++++
 tb/tb_ahfp_add.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahfp_add_if.sv
// ahfp_add_if -- operand/result bundle for the ahfp_add binary32 adder.
//   dataa  : operand A (binary32)
//   datab  : operand B (binary32)
//   result : registered binary32 sum
// Modports: master drives the operands and observes the result;
//           slave (the adder) consumes the operands and drives the result.
interface ahfp_add_if;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;

  modport master (output dataa, output datab, input result);
  modport slave  (input dataa, input datab, output result);
endinterface

// File: rtl/ahfp_add.sv
// ahfp_add -- single-cycle binary32 adder (round-to-nearest-even, flush-to-zero).
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; result forced to 0 while low
//   bus   : ahfp_add_if.slave (dataa, datab in; result out, registered)
// The datapath is combinational from the operands into one output register,
// so a new operand pair is accepted every cycle with one cycle of latency.
// Build option: define AHFP_ADD_SPECIALS_EN for IEEE NaN/Inf handling and
// overflow to Inf; without it exponent 255 is an ordinary value and overflow
// saturates to the signed maximum finite value.
module ahfp_add (
  input  logic      clk,
  input  logic      rst_n,
  ahfp_add_if.slave bus
);

  logic              sa, sb;
  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic              za, zb;
  logic [30:0]       mag_a, mag_b;
  logic              s_l;
  logic [7:0]        e_l, e_s;
  logic [22:0]       f_l, f_s;
  logic              z_l, z_s;
  logic [23:0]       m_l, m_s;
  logic [7:0]        diff;
  logic [49:0]       wide;
  logic [26:0]       al_sig, sm_sig;
  logic              eff_sub;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic [26:0]       norm;
  logic signed [9:0] exp_n, exp_o;
  logic [23:0]       mant;
  logic              round_up;
  logic [24:0]       mant_r;
  logic [22:0]       frac_o;
  logic [31:0]       sum_c;
  logic [31:0]       result_q;
`ifdef AHFP_ADD_SPECIALS_EN
  logic              a_nan, b_nan, a_inf, b_inf;
`endif

  always_comb begin
    sa = bus.dataa[31];
    ea = bus.dataa[30:23];
    fa = bus.dataa[22:0];
    sb = bus.datab[31];
    eb = bus.datab[30:23];
    fb = bus.datab[22:0];

    // Denormals are treated as zero, so they drop out of the magnitude compare.
    za    = (ea == 8'd0);
    zb    = (eb == 8'd0);
    mag_a = za ? '0 : bus.dataa[30:0];
    mag_b = zb ? '0 : bus.datab[30:0];

    // Larger magnitude first; its sign is the result sign.
    if (mag_b > mag_a) begin
      s_l = sb; e_l = eb; f_l = fb; z_l = zb;
      e_s = ea; f_s = fa; z_s = za;
    end else begin
      s_l = sa; e_l = ea; f_l = fa; z_l = za;
      e_s = eb; f_s = fb; z_s = zb;
    end

    m_l  = z_l ? '0 : {1'b1, f_l};
    m_s  = z_s ? '0 : {1'b1, f_s};
    diff = e_l - e_s;

    // 27-bit significands: 24 bits + guard, round, sticky. The 50-bit window
    // catches every bit shifted out below the sticky position.
    al_sig = {m_l, 3'b000};
    wide   = {m_s, 26'd0} >> diff;
    if (diff >= 8'd26) begin
      sm_sig = {26'd0, |m_s};
    end else begin
      sm_sig = {wide[49:24], wide[23] | (|wide[22:0])};
    end

    eff_sub = sa ^ sb;
    if (eff_sub) begin
      sum = {1'b0, al_sig} - {1'b0, sm_sig};
    end else begin
      sum = {1'b0, al_sig} + {1'b0, sm_sig};
    end

    // Leading-zero count over the 27-bit significand; the highest set bit wins.
    lz = 5'd0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = $signed({2'b00, e_l}) + 10'sd1;
    end else begin
      norm  = sum[26:0] << lz;
      exp_n = $signed({2'b00, e_l}) - $signed({5'd0, lz});
    end

    mant     = norm[26:3];
    round_up = norm[2] & (norm[1] | norm[0] | mant[0]);
    mant_r   = {1'b0, mant} + {24'd0, round_up};
    if (mant_r[24]) begin
      frac_o = mant_r[23:1];
      exp_o  = exp_n + 10'sd1;
    end else begin
      frac_o = mant_r[22:0];
      exp_o  = exp_n;
    end

    if (z_s) begin
      // Zero on the small side passes the large operand through untouched.
      sum_c = z_l ? {sa & sb, 31'd0} : {s_l, e_l, f_l};
    end else if (sum == 28'd0) begin
      sum_c = '0;
    end else if (exp_o < 10'sd1) begin
      sum_c = {s_l, 31'd0};
    end else if (exp_o > 10'sd254) begin
`ifdef AHFP_ADD_SPECIALS_EN
      sum_c = {s_l, 8'hFF, 23'd0};
`else
      sum_c = {s_l, 8'hFE, 23'h7FFFFF};
`endif
    end else begin
      sum_c = {s_l, exp_o[7:0], frac_o};
    end

`ifdef AHFP_ADD_SPECIALS_EN
    a_nan = (ea == 8'hFF) && (fa != 23'd0);
    b_nan = (eb == 8'hFF) && (fb != 23'd0);
    a_inf = (ea == 8'hFF) && (fa == 23'd0);
    b_inf = (eb == 8'hFF) && (fb == 23'd0);
    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
      sum_c = 32'h7FC00000;
    end else if (a_inf) begin
      sum_c = bus.dataa;
    end else if (b_inf) begin
      sum_c = bus.datab;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else begin
      result_q <= sum_c;
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_ahfp_add.sv
module tb_ahfp_add;

  logic clk;
  logic rst_n;
  logic drv_valid;

  ahfp_add_if bus ();

  ahfp_add dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } txn_t;

  txn_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, got, want);
    end
  endtask

  // Reference: exact integer sum of the two scaled significands, then a single
  // round-to-nearest-even to 24 bits; flush/saturate on the final exponent.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic [30:0] ma, mb;
    logic [31:0] lw, sw;
    logic [23:0] ml, ms;
    logic [79:0] x, q, rem, half;
    int          el, es, d, p, sh, e;
    ma = (a[30:23] == 8'd0) ? 31'd0 : a[30:0];
    mb = (b[30:23] == 8'd0) ? 31'd0 : b[30:0];
    if (ma == 31'd0 && mb == 31'd0) return {a[31] & b[31], 31'd0};
    if (mb == 31'd0) return a;
    if (ma == 31'd0) return b;
    if (ma == mb && a[31] != b[31]) return 32'd0;
    if (ma >= mb) begin lw = a; sw = b; end
    else begin lw = b; sw = a; end
    el = int'(lw[30:23]);
    es = int'(sw[30:23]);
    ml = {1'b1, lw[22:0]};
    ms = {1'b1, sw[22:0]};
    d  = el - es;
    if (d > 40) return lw;
    x = {56'd0, ml} << d;
    if (lw[31] == sw[31]) x = x + {56'd0, ms};
    else x = x - {56'd0, ms};
    p = 0;
    for (int i = 0; i < 80; i++) if (x[i]) p = i;
    if (p > 23) begin
      sh   = p - 23;
      q    = x >> sh;
      rem  = x & ((80'd1 << sh) - 80'd1);
      half = 80'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 80'd1;
      if (q[24]) begin q = q >> 1; sh++; end
      e = es + sh;
    end else begin
      q = x << (23 - p);
      e = es - (23 - p);
    end
    if (e < 1) return {lw[31], 31'd0};
`ifdef AHFP_ADD_SPECIALS_EN
    if (e > 254) return {lw[31], 8'hFF, 23'd0};
`else
    if (e > 254) return {lw[31], 8'hFE, 23'h7FFFFF};
`endif
    return {lw[31], 8'(e), q[22:0]};
  endfunction

  // Apply one operand pair for the coming edge; called at posedge+1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
    txn_t t;
    bus.dataa = a;
    bus.datab = b;
    drv_valid = 1'b1;
    t.a = a; t.b = b; t.exp = want;
    exp_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic issue_model(input logic [31:0] a, input logic [31:0] b);
    issue(a, b, ref_add(a, b));
  endtask

  function automatic logic [31:0] rand_pair_b(input logic [31:0] a);
    int          ea, eb, k;
    logic [31:0] b;
    ea = int'(a[30:23]);
    b  = {1'($urandom_range(0, 1)), 8'd0, 23'($urandom)};
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: begin
        k  = $urandom_range(0, 30);
        eb = (ea > 30) ? ea - k : ea + k;
        b[30:23] = 8'(eb);
      end
      5, 6: b[30:23] = 8'($urandom_range(1, 250));
      7: b[30:23] = 8'd0;
      8: b = {~a[31], a[30:0]};
      default: b = {~a[31], a[30:23], a[22:0] ^ 23'($urandom_range(1, 7))};
    endcase
    return b;
  endfunction

  // Monitor: whenever an operand pair was captured by an edge out of reset,
  // the registered result is compared against the oldest expectation.
  logic mon_v;
  initial begin
    txn_t t;
    forever begin
      @(posedge clk);
      mon_v = drv_valid & rst_n;
      #1;
      if (mon_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output: got %08h expected none", bus.result);
        end else begin
          t = exp_q.pop_front();
          check($sformatf("sum %08h+%08h", t.a, t.b), bus.result, t.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    rst_n     = 1'b0;
    drv_valid = 1'b0;
    bus.dataa = 32'h3F800000;
    bus.datab = 32'h40000000;
    #2;
    check("reset_value", bus.result, 32'h00000000);
    @(posedge clk);
    #1;
    check("reset_held_over_edge", bus.result, 32'h00000000);
    @(posedge clk);
    #1;
    bus.dataa = 32'h3F800000;
    bus.datab = 32'h40000000;
    drv_valid = 1'b1;
    begin
      txn_t t;
      t.a = 32'h3F800000; t.b = 32'h40000000; t.exp = 32'h40400000;
      exp_q.push_back(t);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(32'h40000000, 32'h40800000, 32'h40C00000);
    issue(32'h40400000, 32'h40600000, 32'h40D00000);
    issue(32'h00000000, 32'h00000000, 32'h00000000);
    issue(32'h43FA0000, 32'h41133333, 32'h43FE999A);
    issue(32'h41EC0000, 32'h453BF800, 32'h453DD000);
    issue(32'h46A5E51F, 32'h435FAB85, 32'h46A7A476);
    issue(32'h3F8E363B, 32'h3AA137F4, 32'h3F8E5E89);
    issue(32'h42FF999A, 32'h42FCCCCD, 32'h437E3334);
    issue(32'h4640E400, 32'h47F12040, 32'h48049E60);
    issue(32'h40400000, 32'hBF800000, 32'h40000000);
    issue(32'h3F800001, 32'hBF800000, 32'h34000000);
    issue(32'h3F800000, 32'hBF800000, 32'h00000000);
    issue(32'hBF800000, 32'h3F800000, 32'h00000000);
    issue(32'h80000000, 32'h80000000, 32'h80000000);
    issue(32'h00000000, 32'h80000000, 32'h00000000);
    issue(32'h80000000, 32'h00000000, 32'h00000000);
    issue(32'h80000001, 32'h80000002, 32'h80000000);
    issue(32'h00000005, 32'hC0490FDB, 32'hC0490FDB);
    issue(32'h3F800000, 32'h80000005, 32'h3F800000);
    issue(32'h80800001, 32'h00800000, 32'h80000000);
    issue(32'h4B800000, 32'h33800000, 32'h4B800000);
`ifdef AHFP_ADD_SPECIALS_EN
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    issue(32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000);
    issue(32'h7F800000, 32'hFF800000, 32'h7FC00000);
    issue(32'h7F800001, 32'h3F800000, 32'h7FC00000);
    issue(32'h3F800000, 32'hFF800000, 32'hFF800000);
`else
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF);
    issue(32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF7FFFFF);
`endif

    for (int n = 0; n < 300; n++) begin
      a = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 250)), 23'($urandom)};
      b = rand_pair_b(a);
      issue_model(a, b);
    end

    // Mid-stream reset: result holds a live sum, then clears without an edge.
    issue(32'h40400000, 32'h40600000, 32'h40D00000);
    drv_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_async_clear", bus.result, 32'h00000000);
    @(posedge clk);
    #1;
    check("reset_mid_held", bus.result, 32'h00000000);
    a = 32'h43FA0000;
    b = 32'h41133333;
    bus.dataa = a;
    bus.datab = b;
    drv_valid = 1'b1;
    begin
      txn_t t;
      t.a = a; t.b = b; t.exp = ref_add(a, b);
      exp_q.push_back(t);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 100; n++) begin
      a = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 250)), 23'($urandom)};
      b = rand_pair_b(a);
      issue_model(a, b);
    end
    drv_valid = 1'b0;

    for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
